// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and baud divider table shared by the UART transmitter and receiver
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
  localparam logic [15:0] DIV_9600    = 16'd1041;
  localparam logic [15:0] DIV_19200   = 16'd520;
  localparam logic [15:0] DIV_38400   = 16'd259;
  localparam logic [15:0] DIV_57600   = 16'd173;
  localparam logic [15:0] DIV_115200  = 16'd86;
  localparam logic [15:0] DIV_DEFAULT = DIV_9600;
  function automatic logic [15:0] baud_to_div(input logic [31:0] baud);
    return baud == 32'd9600   ? DIV_9600   :
           baud == 32'd19200  ? DIV_19200  :
           baud == 32'd38400  ? DIV_38400  :
           baud == 32'd57600  ? DIV_57600  :
           baud == 32'd115200 ? DIV_115200 : DIV_DEFAULT;
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: pulses tick_o once every div_i+1 cycles while enabled, held clear otherwise
module uart_baud_tick (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        en_i,
  input  logic [15:0] div_i,
  output logic        tick_o
);
  logic [15:0] cnt;
  assign tick_o = en_i && cnt == div_i;
  always_ff @(posedge clk_i) begin
    if (!rstn_i || !en_i || tick_o) cnt <= '0;
    else cnt <= cnt + 16'd1;
  end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8-bit LSB-first UART transmitter, optional even parity, one or two stop bits
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 10_000_000
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [31:0] baudrate_i,
  input  logic        parity_en_i,
  input  logic        stopbit_i,
  input  logic [7:0]  tx_data_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic        tx_o,
  output logic        busy_o
);
  if (CLK_FREQ_HZ < 1) begin : g_clk_check
    $error("uart_tx: CLK_FREQ_HZ must be positive");
  end
  state_e      state;
  logic [7:0]  shift;
  logic [2:0]  bit_cnt;
  logic        stop_cnt;
  logic        par_en_q;
  logic        stop2_q;
  logic        parity_q;
  logic [15:0] div_q;
  logic        bit_end;
  assign tx_ready_o = state == IDLE;
  uart_baud_tick u_tick (
    .clk_i (clk_i),
    .rstn_i(rstn_i),
    .en_i  (state != IDLE),
    .div_i (div_q),
    .tick_o(bit_end)
  );
  // tx_o is assigned alongside each state change so the line moves on the same edge
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state    <= IDLE;
      tx_o     <= 1'b1;
      busy_o   <= 1'b0;
      shift    <= 8'hFF;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
      parity_q <= 1'b0;
      div_q    <= DIV_DEFAULT;
    end else begin
      case (state)
        IDLE: if (tx_valid_i) begin
          state    <= START;
          tx_o     <= 1'b0;
          busy_o   <= 1'b1;
          shift    <= tx_data_i;
          parity_q <= ^tx_data_i;
          div_q    <= baud_to_div(baudrate_i);
          par_en_q <= parity_en_i;
          stop2_q  <= stopbit_i;
          bit_cnt  <= '0;
          stop_cnt <= 1'b0;
        end
        START: if (bit_end) begin
          state <= DATA;
          tx_o  <= shift[0];
        end
        DATA: if (bit_end) begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state <= par_en_q ? PARITY : STOP;
            tx_o  <= par_en_q ? parity_q : 1'b1;
          end else begin
            shift <= {1'b1, shift[7:1]};
            tx_o  <= shift[1];
          end
        end
        PARITY: if (bit_end) begin
          state <= STOP;
          tx_o  <= 1'b1;
        end
        STOP: if (bit_end) begin
          stop_cnt <= stop_cnt + 1'b1;
          if (stop_cnt == stop2_q) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          tx_o   <= 1'b1;
          busy_o <= 1'b0;
        end
      endcase
    end
  end
endmodule
